// File: rtl/router_1xn.sv
// 1-to-N framed packet router: input FSM, parity tracking, per-port FIFOs and idle-flush timers.
// Optional build macro ROUTER_PARITY_CHECK_EN enables the parity-byte compare onto err.
module router_1xn #(
    parameter int DATA_W  = 8,
    parameter int N_PORTS = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pkt_valid,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [N_PORTS-1:0]        read_enb,
    output logic [N_PORTS*DATA_W-1:0] data_out,
    output logic [N_PORTS-1:0]        vld_out,
    output logic                      busy,
    output logic                      err,
    output logic                      drop
);
    // state      | meaning
    // IDLE       | waiting for a header byte
    // WAIT_EMPTY | header held off until the destination FIFO drains
    // LOAD       | storing payload bytes, tracking parity
    // PARITY     | storing and checking the trailing parity byte
    // DROP       | discarding the rest of the current frame
    localparam int ADDR_W = $clog2(N_PORTS);
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD, PARITY, DROP} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] dest, dest_next, wr_sel;
    logic [LEN_W-1:0]  count, count_next;
    logic [DATA_W-1:0] parity, parity_next;
    logic              err_set, drop_set, fsm_wr;

    logic [N_PORTS-1:0] empty, full, wr_en, rd_en, flush;

    logic [ADDR_W-1:0] hdr_dest;
    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_bad;

    assign hdr_dest = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_W-1:ADDR_W];
    assign hdr_bad  = (int'(hdr_dest) >= N_PORTS);

    always_comb begin
        state_next  = state;
        dest_next   = dest;
        count_next  = count;
        parity_next = parity;
        err_set     = 1'b0;
        drop_set    = 1'b0;
        fsm_wr      = 1'b0;
        wr_sel      = dest;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (hdr_bad) begin
                        state_next = DROP;
                        drop_set   = 1'b1;
                    end else if (empty[hdr_dest]) begin
                        fsm_wr      = 1'b1;
                        wr_sel      = hdr_dest;
                        dest_next   = hdr_dest;
                        parity_next = data_in;
                        count_next  = hdr_len;
                        state_next  = (hdr_len == '0) ? PARITY : LOAD;
                    end else begin
                        dest_next  = hdr_dest;
                        state_next = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (empty[dest]) state_next = IDLE;
            end
            LOAD: begin
                busy = full[dest];
                if (flush[dest]) begin
                    state_next = DROP;
                    drop_set   = 1'b1;
                end else if (!pkt_valid) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end else if (!full[dest]) begin
                    fsm_wr      = 1'b1;
                    parity_next = parity ^ data_in;
                    count_next  = count - LEN_W'(1);
                    if (count == LEN_W'(1)) state_next = PARITY;
                end
            end
            PARITY: begin
                busy = full[dest];
                if (flush[dest]) begin
                    state_next = DROP;
                    drop_set   = 1'b1;
                end else if (!pkt_valid) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end else if (!full[dest]) begin
                    fsm_wr     = 1'b1;
                    state_next = IDLE;
`ifdef ROUTER_PARITY_CHECK_EN
                    err_set    = (data_in != parity);
`endif
                end
            end
            DROP: begin
                if (!pkt_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            dest   <= '0;
            count  <= '0;
            parity <= '0;
            err    <= 1'b0;
            drop   <= 1'b0;
        end else begin
            state  <= state_next;
            dest   <= dest_next;
            count  <= count_next;
            parity <= parity_next;
            err    <= err_set;
            drop   <= drop_set;
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] data_q;
        logic [TMR_W-1:0]  tmr;
        logic              vld_q, counting;

        assign wr_en[g]    = fsm_wr && (int'(wr_sel) == g);
        assign empty[g]    = (wr_ptr == rd_ptr);
        assign full[g]     = ((wr_ptr - rd_ptr) == PTR_W'(DEPTH));
        assign rd_en[g]    = read_enb[g] & vld_q;
        assign counting    = vld_q & ~read_enb[g];
        assign flush[g]    = counting && (tmr == TMR_W'(TIMEOUT - 1));
        assign wr_ptr_next = flush[g] ? '0 : wr_ptr + PTR_W'(wr_en[g]);
        assign rd_ptr_next = flush[g] ? '0 : rd_ptr + PTR_W'(rd_en[g]);

        assign vld_out[g]                   = vld_q;
        assign data_out[g*DATA_W +: DATA_W] = data_q;

        always_ff @(posedge clk) begin
            if (wr_en[g]) mem[wr_ptr[AW-1:0]] <= data_in;
        end

        // vld rises one cycle after the first write but drops on the edge that empties the FIFO
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                tmr    <= '0;
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                wr_ptr <= wr_ptr_next;
                rd_ptr <= rd_ptr_next;
                vld_q  <= ~empty[g] & (wr_ptr_next != rd_ptr_next);
                if (rd_en[g]) data_q <= mem[rd_ptr[AW-1:0]];
                if (!counting || flush[g]) tmr <= '0;
                else                       tmr <= tmr + TMR_W'(1);
            end
        end
    end
endmodule
